// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM (T0 fetch, T1 decode, T2 ALU, T3 writeback) for the 16-bit datapath.
// Latency: mv/mvi/invalid retire 2 cycles after the fetch edge, ALU ops 4; outputs are combinational from state/IR/Run.
// Backpressure: none; p_Run is sampled only in T0 and a held p_Run chains fetches with no bubble.
// Optional build macro CTRL_SHIFT_EN: decodes 0110 sll / 0111 srl as ALU ops (otherwise they are invalid).
module control_unit #(
   parameter int NREGS   = 8,
   parameter int BUS_DIN = 9,
   parameter int BUS_G   = 8
) (
   input  logic             p_Clock,
   input  logic             p_Clear,
   input  logic             p_Run,
   input  logic [15:0]      p_IR,
   output logic [NREGS-1:0] p_RegWriteOn,
   output logic             p_IRWriteOn,
   output logic             p_AWriteOn,
   output logic             p_GWriteOn,
   output logic [3:0]       p_BusSel,
   output logic [2:0]       p_AluOp,
   output logic             p_Done,
   output logic [1:0]       p_State
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [3:0] OP_MV  = 4'b0000;
   localparam logic [3:0] OP_MVI = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;

   state_t r_state;
   state_t w_next;

   logic [3:0]       w_op;
   logic [2:0]       w_rx;
   logic [2:0]       w_ry;
   logic             w_is_alu;
   logic [2:0]       w_alu_code;
   logic [NREGS-1:0] w_rx_onehot;

   logic [NREGS-1:0] w_regw;
   logic             w_irw;
   logic             w_aw;
   logic             w_gw;
   logic [3:0]       w_bus;
   logic [2:0]       w_alu;
   logic             w_done;

   // Low six IR bits carry no control meaning; folded here so they are visibly accounted for.
   logic w_unused;
   assign w_unused = ^p_IR[5:0];

   assign w_op = p_IR[15:12];
   assign w_rx = p_IR[11:9];
   assign w_ry = p_IR[8:6];

   // Rx as a one-hot register write enable; only one bit can ever be set.
   always_comb begin
      w_rx_onehot       = '0;
      w_rx_onehot[w_rx] = 1'b1;
   end

   // Opcode classification: which opcodes take the T2/T3 ALU path and which ALU op they use.
   always_comb begin
      w_is_alu   = 1'b0;
      w_alu_code = ALU_ADD;
      case (w_op)
         OP_ADD: begin w_is_alu = 1'b1; w_alu_code = ALU_ADD; end
         OP_SUB: begin w_is_alu = 1'b1; w_alu_code = ALU_SUB; end
         OP_AND: begin w_is_alu = 1'b1; w_alu_code = ALU_AND; end
         OP_SLT: begin w_is_alu = 1'b1; w_alu_code = ALU_SLT; end
`ifdef CTRL_SHIFT_EN
         OP_SLL: begin w_is_alu = 1'b1; w_alu_code = ALU_SLL; end
         OP_SRL: begin w_is_alu = 1'b1; w_alu_code = ALU_SRL; end
`else
         // Without the shifter these retire in T1 as invalid, and ALU codes 4/5 never appear.
         OP_SLL: begin w_is_alu = 1'b0; w_alu_code = ALU_ADD; end
         OP_SRL: begin w_is_alu = 1'b0; w_alu_code = ALU_ADD; end
`endif
         default: begin w_is_alu = 1'b0; w_alu_code = ALU_ADD; end
      endcase
   end

   // Next-state and per-state control outputs; anything not driven in a state stays 0.
   always_comb begin
      w_next = r_state;
      w_regw = '0;
      w_irw  = 1'b0;
      w_aw   = 1'b0;
      w_gw   = 1'b0;
      w_bus  = 4'd0;
      w_alu  = ALU_ADD;
      w_done = 1'b0;
      case (r_state)
         T0: begin
            if (p_Run) begin
               w_bus  = 4'(BUS_DIN);
               w_irw  = 1'b1;
               w_next = T1;
            end
         end
         T1: begin
            if (w_op == OP_MV) begin
               w_bus  = {1'b0, w_ry};
               w_regw = w_rx_onehot;
               w_done = 1'b1;
               w_next = T0;
            end else if (w_op == OP_MVI) begin
               // Immediate word is presented on DIN during this cycle.
               w_bus  = 4'(BUS_DIN);
               w_regw = w_rx_onehot;
               w_done = 1'b1;
               w_next = T0;
            end else if (w_is_alu) begin
               w_bus  = {1'b0, w_rx};
               w_aw   = 1'b1;
               w_next = T2;
            end else begin
               // Unknown opcode: retire immediately with no side effects.
               w_done = 1'b1;
               w_next = T0;
            end
         end
         T2: begin
            // For shifts the amount is the low bits of Ry, carried on the bus here.
            w_bus  = {1'b0, w_ry};
            w_alu  = w_alu_code;
            w_gw   = 1'b1;
            w_next = T3;
         end
         T3: begin
            w_bus  = 4'(BUS_G);
            w_regw = w_rx_onehot;
            w_done = 1'b1;
            w_next = T0;
         end
         default: begin
            w_next = T0;
         end
      endcase
   end

   // State register: the only storage; p_Clear wins over everything and abandons any instruction.
   always_ff @(posedge p_Clock) begin
      if (p_Clear) begin
         r_state <= T0;
      end else begin
         r_state <= w_next;
      end
   end

   // While p_Clear is asserted every output, including the debug state, reads as 0.
   always_comb begin
      if (p_Clear) begin
         p_RegWriteOn = '0;
         p_IRWriteOn  = 1'b0;
         p_AWriteOn   = 1'b0;
         p_GWriteOn   = 1'b0;
         p_BusSel     = 4'd0;
         p_AluOp      = 3'd0;
         p_Done       = 1'b0;
         p_State      = 2'd0;
      end else begin
         p_RegWriteOn = w_regw;
         p_IRWriteOn  = w_irw;
         p_AWriteOn   = w_aw;
         p_GWriteOn   = w_gw;
         p_BusSel     = w_bus;
         p_AluOp      = w_alu;
         p_Done       = w_done;
         p_State      = r_state;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of control_unit outputs per cycle.
// Inputs change 2ns after each rising edge; outputs sampled 1ns later, well away from the edge.
// Expected control words are hand-computed constants for each step.
module tb_control_unit;

   logic        p_Clock;
   logic        p_Clear;
   logic        p_Run;
   logic [15:0] p_IR;
   logic [7:0]  p_RegWriteOn;
   logic        p_IRWriteOn;
   logic        p_AWriteOn;
   logic        p_GWriteOn;
   logic [3:0]  p_BusSel;
   logic [2:0]  p_AluOp;
   logic        p_Done;
   logic [1:0]  p_State;

   int n_assert = 0;
   int n_fail   = 0;

   control_unit dut (
      .p_Clock      (p_Clock),
      .p_Clear      (p_Clear),
      .p_Run        (p_Run),
      .p_IR         (p_IR),
      .p_RegWriteOn (p_RegWriteOn),
      .p_IRWriteOn  (p_IRWriteOn),
      .p_AWriteOn   (p_AWriteOn),
      .p_GWriteOn   (p_GWriteOn),
      .p_BusSel     (p_BusSel),
      .p_AluOp      (p_AluOp),
      .p_Done       (p_Done),
      .p_State      (p_State)
   );

   initial p_Clock = 1'b0;
   always #5 p_Clock = ~p_Clock;

   task automatic tick();
      @(posedge p_Clock);
      #2;
   endtask

   // Compare the full control word {regw, irw, aw, gw, bus, alu, done, state}.
   task automatic expect_out(input string tag, input logic [7:0] regw, input logic irw,
                             input logic aw, input logic gw, input logic [3:0] bus,
                             input logic [2:0] alu, input logic done, input logic [1:0] st);
      logic [20:0] obs;
      logic [20:0] exp;
      #1;
      obs = {p_RegWriteOn, p_IRWriteOn, p_AWriteOn, p_GWriteOn, p_BusSel, p_AluOp, p_Done, p_State};
      exp = {regw, irw, aw, gw, bus, alu, done, st};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed regw=%h irw=%b aw=%b gw=%b bus=%0d alu=%0d done=%b st=%0d, expected regw=%h irw=%b aw=%b gw=%b bus=%0d alu=%0d done=%b st=%0d",
                tag, obs[20:13], obs[12], obs[11], obs[10], obs[9:6], obs[5:3], obs[2], obs[1:0],
                regw, irw, aw, gw, bus, alu, done, st);
      end
   endtask

   initial begin
      p_Clear = 1'b1;
      p_Run   = 1'b0;
      p_IR    = 16'h0000;

      // Reset: everything zero, even with Run requested.
      tick();
      expect_out("reset_idle", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      p_Run = 1'b1;
      expect_out("reset_run_masked", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      p_Run   = 1'b0;
      p_Clear = 1'b0;
      expect_out("t0_idle", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // mv R1,R2
      p_IR  = 16'h0280;
      p_Run = 1'b1;
      expect_out("mv_t0", 8'h00, 1, 0, 0, 4'd9, 3'd0, 0, 2'd0);
      tick();
      p_Run = 1'b0;
      expect_out("mv_t1", 8'h02, 0, 0, 0, 4'd2, 3'd0, 1, 2'd1);
      tick();
      expect_out("mv_after", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      tick();
      expect_out("idle_stays_t0", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // add R5,R1 interrupted by Clear during T2
      p_IR  = 16'h2A40;
      p_Run = 1'b1;
      expect_out("add_t0", 8'h00, 1, 0, 0, 4'd9, 3'd0, 0, 2'd0);
      tick();
      p_Run = 1'b0;
      expect_out("add_t1", 8'h00, 0, 1, 0, 4'd5, 3'd0, 0, 2'd1);
      tick();
      expect_out("add_t2", 8'h00, 0, 0, 1, 4'd1, 3'd0, 0, 2'd2);
      p_Clear = 1'b1;
      expect_out("clr_mid_t2", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      tick();
      expect_out("clr_cycle1", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      tick();
      p_Clear = 1'b0;
      expect_out("clr_after", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      tick();
      expect_out("clr_no_wb", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // add R5,R1 to completion
      p_Run = 1'b1;
      expect_out("add2_t0", 8'h00, 1, 0, 0, 4'd9, 3'd0, 0, 2'd0);
      tick();
      p_Run = 1'b0;
      expect_out("add2_t1", 8'h00, 0, 1, 0, 4'd5, 3'd0, 0, 2'd1);
      tick();
      expect_out("add2_t2", 8'h00, 0, 0, 1, 4'd1, 3'd0, 0, 2'd2);
      tick();
      expect_out("add2_t3", 8'h20, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      tick();
      expect_out("add2_after", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // Back-to-back: mvi R1 then sub R5,R1 with Run held high
      p_IR  = 16'h1200;
      p_Run = 1'b1;
      expect_out("b2b_mvi_t0", 8'h00, 1, 0, 0, 4'd9, 3'd0, 0, 2'd0);
      tick();
      expect_out("b2b_mvi_t1", 8'h02, 0, 0, 0, 4'd9, 3'd0, 1, 2'd1);
      tick();
      p_IR = 16'h3A40;
      expect_out("b2b_sub_t0", 8'h00, 1, 0, 0, 4'd9, 3'd0, 0, 2'd0);
      tick();
      expect_out("b2b_sub_t1", 8'h00, 0, 1, 0, 4'd5, 3'd0, 0, 2'd1);
      tick();
      expect_out("b2b_sub_t2", 8'h00, 0, 0, 1, 4'd1, 3'd1, 0, 2'd2);
      tick();
      expect_out("b2b_sub_t3", 8'h20, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      p_Run = 1'b0;
      tick();
      expect_out("b2b_after", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // Run pulse seen only in T1 is lost: invalid opcode F
      p_IR  = 16'hF000;
      p_Run = 1'b1;
      tick();
      expect_out("inv_t1", 8'h00, 0, 0, 0, 4'd0, 3'd0, 1, 2'd1);
      tick();
      p_Run = 1'b0;
      tick();
      expect_out("run_not_latched", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      // slt R7,R7
      p_IR  = 16'h5FC0;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      expect_out("slt_t1", 8'h00, 0, 1, 0, 4'd7, 3'd0, 0, 2'd1);
      tick();
      expect_out("slt_t2", 8'h00, 0, 0, 1, 4'd7, 3'd3, 0, 2'd2);
      tick();
      expect_out("slt_t3", 8'h80, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      tick();

      // and R0,R6
      p_IR  = 16'h4180;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      expect_out("and_t1", 8'h00, 0, 1, 0, 4'd0, 3'd0, 0, 2'd1);
      tick();
      expect_out("and_t2", 8'h00, 0, 0, 1, 4'd6, 3'd2, 0, 2'd2);
      tick();
      expect_out("and_t3", 8'h01, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      tick();

      // sll R2,R1 and srl R2,R1
`ifdef CTRL_SHIFT_EN
      p_IR  = 16'h6440;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      expect_out("sll_t1", 8'h00, 0, 1, 0, 4'd2, 3'd0, 0, 2'd1);
      tick();
      expect_out("sll_t2", 8'h00, 0, 0, 1, 4'd1, 3'd4, 0, 2'd2);
      tick();
      expect_out("sll_t3", 8'h04, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      tick();
      p_IR  = 16'h7440;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      tick();
      expect_out("srl_t2", 8'h00, 0, 0, 1, 4'd1, 3'd5, 0, 2'd2);
      tick();
      expect_out("srl_t3", 8'h04, 0, 0, 0, 4'd8, 3'd0, 1, 2'd3);
      tick();
`else
      p_IR  = 16'h6440;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      expect_out("sll_invalid_t1", 8'h00, 0, 0, 0, 4'd0, 3'd0, 1, 2'd1);
      tick();
      expect_out("sll_invalid_after", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);
      p_IR  = 16'h7440;
      p_Run = 1'b1;
      tick();
      p_Run = 1'b0;
      expect_out("srl_invalid_t1", 8'h00, 0, 0, 0, 4'd0, 3'd0, 1, 2'd1);
      tick();
`endif
      expect_out("final_idle", 8'h00, 0, 0, 0, 4'd0, 3'd0, 0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
